// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Holds the buffer entry layout, the reset PC default and the NOP encoding.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_prefetch_if.sv
// ROM and decode-side signals of the prefetch unit.
// The master side is the prefetcher; the slave side is ROM plus decode.
interface inst_prefetch_if;

    logic [11:0] rom_addr;
    logic [31:0] rom_inst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output rom_addr, out_valid, out_inst, out_pc,
        input  rom_inst, fetch_en, redirect_valid,
        input  redirect_pc, out_ready
    );

    modport slave (
        input  rom_addr, out_valid, out_inst, out_pc,
        output rom_inst, fetch_en, redirect_valid,
        output redirect_pc, out_ready
    );

endinterface

// File: rtl/pf_fifo.sv
// Flop-based prefetch buffer with push, pop and a priority flush.
// Head entry is read combinationally; there is no write-to-read bypass.
module pf_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    // Pointer and occupancy next-state; flush overrides push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + AW'(1);
            if (pop_i)  head_d = head_q + AW'(1);
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless while not counted.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: walks the ROM from fetch_pc into a small buffer.
// Redirects flush the buffer and restart fetching at the word-aligned target.
module inst_prefetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DFLT
) (
    input  logic clk,
    input  logic reset_n,
    inst_prefetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   target;
    logic [CW-1:0] count;
    logic          valid;
    logic          push;
    logic          pop;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    assign target = bus.redirect_pc & 32'hFFFF_FFFC;
    assign valid  = (count != '0);
    assign pop    = valid & bus.out_ready;
    assign push   = bus.fetch_en & ~bus.redirect_valid
                  & ((count < CW'(DEPTH)) | pop);

    assign wr_entry = '{pc: fetch_pc_q, inst: bus.rom_inst};

    pf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .wdata_i (wr_entry),
        .count_o (count),
        .head_o  (head)
    );

    // Fetch PC next-state: redirect wins, otherwise advance on push.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) fetch_pc_d = target;
        else if (push)          fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fetch_pc_q <= RESET_PC;
        else          fetch_pc_q <= fetch_pc_d;
    end

    assign bus.rom_addr  = fetch_pc_q[11:0];
    assign bus.out_valid = valid;
    assign bus.out_inst  = valid ? head.inst : NOP_INST;
    assign bus.out_pc    = valid ? head.pc : RESET_PC;

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch against a queue-based model.
// Directed scenarios first, then a randomized stream.
module tb_inst_prefetch;

    localparam int DEPTH = 4;

    logic clk;
    logic reset_n;

    inst_prefetch_if bus ();

    inst_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] rom [1024];
    assign bus.rom_inst = rom[bus.rom_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] q[$];
    logic [31:0] mpc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
        chk("rom_addr", {20'd0, bus.rom_addr}, {20'd0, mpc[11:0]});
        if (q.size() != 0) begin
            chk("out_pc", bus.out_pc, q[0][63:32]);
            chk("out_inst", bus.out_inst, q[0][31:0]);
        end
    endtask

    task automatic step();
        logic do_pop;
        logic do_push;
        logic [31:0] pc;
        do_pop  = (q.size() != 0) && bus.out_ready;
        do_push = bus.fetch_en && !bus.redirect_valid
               && (q.size() < DEPTH || do_pop);
        pc = mpc;
        @(posedge clk);
        if (bus.redirect_valid) begin
            q.delete();
            mpc = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back({pc, rom[pc[11:2]]});
                mpc = pc + 32'd4;
            end
        end
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        mpc = 32'h0;
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_inst", bus.out_inst, 32'h0000_0013);
        chk("rst_pc", bus.out_pc, 32'h0);
        chk("rst_addr", {20'd0, bus.rom_addr}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[0] = 32'h0000_0013;
        rom[1] = 32'h2000_05B7;
        bus.fetch_en       = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        reset_n            = 1'b1;
        mpc                = 32'h0;
        #2;

        // basic stream
        do_reset();
        step();
        chk("first_pc", bus.out_pc, 32'h0);
        chk("first_inst", bus.out_inst, 32'h0000_0013);
        step();
        chk("second_pc", bus.out_pc, 32'h4);
        chk("second_inst", bus.out_inst, 32'h2000_05B7);

        // backpressure to full, then drain in order
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("stall_addr", {20'd0, bus.rom_addr}, 32'h10);
        chk("stall_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_pc", bus.out_pc, 32'(i * 4));
            step();
        end

        // redirect on a full buffer with pop requested
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0043;
        bus.out_ready      = 1'b1;
        step();
        chk("redir_empty", {31'd0, bus.out_valid}, 32'd0);
        bus.redirect_valid = 1'b0;
        step();
        chk("redir_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("redir_pc", bus.out_pc, 32'h40);

        // back-to-back redirects
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        step();
        bus.redirect_pc    = 32'hC0;
        step();
        bus.redirect_valid = 1'b0;
        step();
        chk("b2b_pc", bus.out_pc, 32'hC0);

        // fetch_en gating
        do_reset();
        bus.out_ready = 1'b0;
        step();
        step();
        bus.fetch_en  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("gate_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("gate_addr", {20'd0, bus.rom_addr}, 32'h8);
        bus.fetch_en = 1'b1;
        step();
        chk("resume_pc", bus.out_pc, 32'h8);

        // asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        step();
        step();
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
        q.delete();
        mpc = 32'h0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("post_rst_pc", bus.out_pc, 32'h0);

        // randomized stream, including 32-bit pc wrap
        for (int i = 0; i < 400; i++) begin
            bus.fetch_en       = ($urandom_range(3) != 0);
            bus.out_ready      = $urandom_range(1);
            bus.redirect_valid = ($urandom_range(19) == 0);
            if ($urandom_range(3) == 0)
                bus.redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15);
            else
                bus.redirect_pc = $urandom_range(32'h1FFF);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of prefetch buffer entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the byte address of the first fetch after reset.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 rom_addr  out  12  byte address presented to the instruction ROM (combinational read, word = addr>>2).
REQ-006 rom_inst  in  32  ROM data for rom_addr, valid in the same cycle.
REQ-007 fetch_en  in  1  when high, the block SHALL be allowed to push new ROM words.
REQ-008 redirect_valid  in  1  branch/jump redirect request.
REQ-009 redirect_pc  in  32  redirect target byte address.
REQ-010 out_valid  out  1  head entry is available to decode.
REQ-011 out_inst  out  32  head instruction.
REQ-012 out_pc  out  32  byte address of the head instruction.
REQ-013 out_ready  in  1  decode accepts the head entry when high together with out_valid.

Function
REQ-014 Block SHALL hold a 32-bit fetch_pc register; rom_addr SHALL equal fetch_pc[11:0] combinationally.
REQ-015 push = fetch_en & ~redirect_valid & (count<DEPTH | pop); pop = out_valid & out_ready.
REQ-016 On push, entry {fetch_pc, rom_inst} SHALL be written at the tail and fetch_pc SHALL advance by 4 (modulo 2^32).
REQ-017 With no push and no redirect, fetch_pc SHALL hold.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged, including at count==DEPTH.
REQ-019 No bypass: an entry pushed at edge N SHALL first appear on out_* after edge N; push into an empty buffer never drives out_valid in the same cycle.
REQ-020 out_valid SHALL equal (count!=0); out_inst/out_pc SHALL come from the head entry and stay stable while out_valid & ~out_ready.
REQ-021 Redirect SHALL take priority over push and pop: at the sampling edge, count SHALL clear, head/tail pointers SHALL reset, and fetch_pc SHALL load {redirect_pc[31:2],2'b00}.
REQ-022 Redirect latency: redirect sampled at edge E -> out_valid low after E; target word pushed at E+1 (if fetch_en) -> out_valid high with out_pc=target after E+1.
REQ-023 Back-to-back redirects SHALL each take effect; only the last target is fetched.
REQ-024 count==DEPTH without pop SHALL stall fetch_pc and suppress writes; no entry is overwritten or lost.
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-026 fetch_pc beyond 0xFFF SHALL still increment in full 32 bits; rom_addr wraps via truncation; out_pc carries the full 32-bit value.

Reset
REQ-027 While reset_n low: fetch_pc=RESET_PC, count=0, pointers=0, out_valid=0; out_inst=32'h0000_0013 (nop) and out_pc=RESET_PC.
REQ-028 Reset assertion mid-operation SHALL clear the buffer immediately (asynchronously); no buffered entry survives.
REQ-029 First push SHALL occur at the first rising edge with reset_n high and fetch_en high.

Structure
REQ-030 Shared package fetch_pkg SHALL hold RESET_PC default, NOP_INST (32'h0000_0013) and typedef fetch_entry_t {pc[31:0], inst[31:0]}.
REQ-031 Buffer SHALL be a sub-module pf_fifo (DEPTH x fetch_entry_t, push/pop/flush, count, head output); the PC/redirect logic stays in inst_prefetch.
REQ-032 Storage SHALL be flops (no RAM macro); no combinational path from out_ready to rom_addr.

Verification
REQ-033 Reset release, fetch_en=1, out_ready=1, ROM word0=0x00000013, word1=0x200005B7 -> out_valid high after edge 1, out_pc=0x0 then 0x4 on consecutive cycles, insts match.
REQ-034 out_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, fetch_pc stops at 0x10, out_pc holds 0x0; raise out_ready -> pcs 0x0,0x4,0x8,0xC,0x10 in order, none skipped.
REQ-035 Full buffer, redirect_valid=1 with redirect_pc=0x0000_0043 and out_ready=1 same cycle -> out_valid low next cycle, then out_pc=0x40, no old entry emitted.
REQ-036 Redirects to 0x80 then 0xC0 on consecutive cycles -> first emitted out_pc=0xC0.
REQ-037 fetch_en=0 after 2 pushes, out_ready=1 -> 2 entries drain, out_valid low, fetch_pc holds 0x8; fetch_en=1 resumes at 0x8.
REQ-038 reset_n pulsed low mid-stream between edges -> out_valid falls without a clock edge; after release, first out_pc=RESET_PC.
